hart_rr_sched: RTL and testbench
================================

# hart_rr_sched

Barrel-hart issue scheduler for the multi-threaded pipeline front end. It emits one hart slot per cycle in fixed round-robin order, together with a 1-bit slot-valid flag that reflects per-hart sleep/wake state. `o_hart_valid` and `o_slot0` are the single-bit control signals that downstream single-bit delay pipelines carry alongside the instruction through later stages. After reset, a startup flush runs for a fixed number of cycles with all slots invalid so downstream stages drain.

## Interface
- `NUM_HARTS`, default 16: hart count. Must be a power of 2, at least 2.
- `HART_ID_W`, default `$clog2(NUM_HARTS)`: hart ID width.
- `FLUSH_CYCLES`, default 16: startup flush length in cycles. Must be a nonzero multiple of `NUM_HARTS`.
- `RESET_ACTIVE_MASK`, default all ones: per-hart active state loaded at reset.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `i_sleep_valid`  in  1  sleep request strobe
- `i_sleep_hart_id`  in  HART_ID_W  hart to put to sleep
- `i_wake_mask`  in  NUM_HARTS  per-hart wake request, level-sampled each cycle
- `o_hart_id`  out  HART_ID_W  hart issued this slot
- `o_hart_valid`  out  1  slot carries a live hart
- `o_slot0`  out  1  `o_hart_id == 0` (rotation start marker, independent of valid)
- `o_all_asleep`  out  1  no hart active (RUN state only)

## Operation
Internal state:
- `cnt`: HART_ID_W-bit slot counter.
- `active`: NUM_HARTS-bit register.
- `fl`: flush counter, at least `$clog2(FLUSH_CYCLES)` bits.
- FSM with two states, FLUSH and RUN.

Reset, at any edge with `reset=1` (including mid-operation):
- `cnt=0`, `fl=0`, state=FLUSH, `active=RESET_ACTIVE_MASK`.
- All outputs 0: `o_hart_id=0`, `o_hart_valid=0`, `o_slot0=0`, `o_all_asleep=0`.
- In-flight sleep/wake requests are discarded.

Every non-reset edge:
- `cnt <= cnt+1`, wrapping from NUM_HARTS-1 to 0.
- `o_hart_id <= cnt`.
- `o_slot0 <= (cnt==0)`.
- `o_hart_valid <= (state==RUN) & active[cnt]`, using the pre-update `active`.

FSM:
- FLUSH: `fl` increments each edge. When `fl==FLUSH_CYCLES-1`, go to RUN on that edge.
- RUN: remains in RUN until reset.

Active update (non-reset edge, any state):
- `active_next = (active & ~sleep_onehot) | i_wake_mask`.
- `sleep_onehot` is the one-hot of `i_sleep_hart_id` when `i_sleep_valid`, else 0.
- If sleep and wake target the same hart in the same cycle, wake wins and the hart stays active.
- Sleep for an already-sleeping hart has no effect. Wake for an awake hart has no effect.
- `o_all_asleep <= (state==RUN) & (active_next==0)`.

## Timing
- Edge 0 is the first rising edge with `reset=0`.
- After edge e: `cnt=(e+1) mod NUM_HARTS` and `o_hart_id = e mod NUM_HARTS`.
- FLUSH covers edges 0 through FLUSH_CYCLES-1. The RUN transition occurs at edge FLUSH_CYCLES-1.
- First possible `o_hart_valid=1` is after edge FLUSH_CYCLES, with `o_hart_id=0`. With defaults this is edge 16.
- Sleep or wake latency:
  - The request sampled at edge e updates `active` at edge e.
  - It first affects `o_hart_valid` at the next slot for that hart, from edge e+1 onward.
  - A request for the hart whose slot is being issued at edge e does not affect that slot.
- `o_all_asleep` reflects the updated `active` at the same edge the request is sampled.
- Requests during FLUSH update `active` normally. `o_hart_valid` and `o_all_asleep` remain 0 until RUN.
- `o_slot0` toggles in both FLUSH and RUN, one cycle in every NUM_HARTS.

## Test plan
1. Reset release, defaults, no requests: `o_hart_valid=0` after edges 0–15. After edge 16: `o_hart_id=0`, `o_hart_valid=1`. Valid stays 1 every cycle after that, `o_hart_id` cycles 0..15, and `o_slot0=1` every 16th cycle.
2. In RUN, `i_sleep_valid=1`, `i_sleep_hart_id=5` for one cycle: `o_hart_valid=0` on every later slot with `o_hart_id=5`. All other harts stay valid. `o_all_asleep` stays 0.
3. Sleep hart 3 and `i_wake_mask=16'h0008` in the same cycle: hart 3 stays active, and its next slot has `o_hart_valid=1`.
4. Sleep all 16 harts, one per cycle: `o_all_asleep=1` on the edge that sleeps the last hart. Then `i_wake_mask=16'h0001`: `o_all_asleep=0` on the next edge, and the next hart-0 slot is valid.
5. Assert `reset` for one cycle mid-RUN with hart 7 asleep: after that edge, all outputs are 0. The full 16-cycle flush repeats, and hart 7 is valid again after edge 16 with `RESET_ACTIVE_MASK=all ones`.
6. With `RESET_ACTIVE_MASK=16'h0001`, reset release: after edge 16, only slots with `o_hart_id=0` have `o_hart_valid=1`.

Source files
------------

// File: rtl/hart_rr_sched.sv
// rtl/hart_rr_sched.sv - barrel-hart round-robin issue scheduler with sleep/wake and startup flush
module hart_rr_sched #(
  parameter int                 NUM_HARTS         = 16,
  parameter int                 HART_ID_W         = $clog2(NUM_HARTS),
  parameter int                 FLUSH_CYCLES      = 16,
  parameter logic [NUM_HARTS-1:0] RESET_ACTIVE_MASK = {NUM_HARTS{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_sleep_valid,
  input  logic [HART_ID_W-1:0] i_sleep_hart_id,
  input  logic [NUM_HARTS-1:0] i_wake_mask,
  output logic [HART_ID_W-1:0] o_hart_id,
  output logic                 o_hart_valid,
  output logic                 o_slot0,
  output logic                 o_all_asleep
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] ST_FLUSH = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]           state;
  logic [HART_ID_W-1:0] cnt;
  logic [HART_ID_W-1:0] cnt_next;
  logic [FL_W-1:0]      fl;
  logic [NUM_HARTS-1:0] active;
  logic [NUM_HARTS-1:0] sleep_onehot;
  logic [NUM_HARTS-1:0] active_next;
  logic                 run;

  assign run = (state == ST_RUN);

  // Wake is OR-ed in after the sleep clear so a same-cycle wake wins.
  always_comb begin
    sleep_onehot = '0;
    if (i_sleep_valid) sleep_onehot = NUM_HARTS'(1) << i_sleep_hart_id;
    active_next = (active & ~sleep_onehot) | i_wake_mask;
  end

  always_comb begin
    cnt_next = cnt + HART_ID_W'(1);
    if (cnt == HART_ID_W'(NUM_HARTS - 1)) cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_FLUSH;
      cnt          <= '0;
      fl           <= '0;
      active       <= RESET_ACTIVE_MASK;
      o_hart_id    <= '0;
      o_hart_valid <= 1'b0;
      o_slot0      <= 1'b0;
      o_all_asleep <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      o_hart_id    <= cnt;
      o_slot0      <= (cnt == '0);
      o_hart_valid <= run & active[cnt];
      active       <= active_next;
      o_all_asleep <= run & (active_next == '0);
      if (state == ST_FLUSH) begin
        fl <= fl + FL_W'(1);
        if (fl == FL_W'(FLUSH_CYCLES - 1)) state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_hart_rr_sched.sv
// tb/tb_hart_rr_sched.sv - directed self-checking bench for hart_rr_sched
module tb_hart_rr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        sleep_valid;
  logic [3:0]  sleep_id;
  logic [15:0] wake_mask;
  logic [3:0]  hart_id;
  logic        hart_valid;
  logic        slot0;
  logic        all_asleep;

  logic        sleep_valid2;
  logic [3:0]  sleep_id2;
  logic [15:0] wake_mask2;
  logic [3:0]  hart_id2;
  logic        hart_valid2;
  logic        slot02;
  logic        all_asleep2;

  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  logic [3:0] eid;

  always #5 clk = ~clk;

  hart_rr_sched dut (
    .clk(clk), .reset(reset),
    .i_sleep_valid(sleep_valid), .i_sleep_hart_id(sleep_id), .i_wake_mask(wake_mask),
    .o_hart_id(hart_id), .o_hart_valid(hart_valid), .o_slot0(slot0), .o_all_asleep(all_asleep)
  );

  hart_rr_sched #(.RESET_ACTIVE_MASK(16'h0001)) dut_mask (
    .clk(clk), .reset(reset),
    .i_sleep_valid(sleep_valid2), .i_sleep_hart_id(sleep_id2), .i_wake_mask(wake_mask2),
    .o_hart_id(hart_id2), .o_hart_valid(hart_valid2), .o_slot0(slot02), .o_all_asleep(all_asleep2)
  );

  // Edge e has just happened when step returns; outputs sampled at the falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
    e = e + 1;
    eid = 4'(e % 16);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sleep_valid = 1'b1; sleep_id = 4'd3; wake_mask = 16'hffff;
    step();
    step();
    vectors++; if (hart_id !== 4'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", hart_id); end
    vectors++; if (hart_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", hart_valid); end
    vectors++; if (slot0 !== 1'b0) begin miscompares++; $display("FAIL reset_slot0 got %b want 0", slot0); end
    vectors++; if (all_asleep !== 1'b0) begin miscompares++; $display("FAIL reset_all_asleep got %b want 0", all_asleep); end
    vectors++; if (hart_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid_mask got %b want 0", hart_valid2); end
    reset = 1'b0; sleep_valid = 1'b0; sleep_id = 4'd0; wake_mask = 16'h0000;
    e = -1;
  endtask

  task automatic test_flush_run;
    repeat (48) begin
      step();
      vectors++; if (hart_id !== eid) begin miscompares++; $display("FAIL flush_id e=%0d got %0d want %0d", e, hart_id, eid); end
      vectors++; if (hart_valid !== (e >= 16)) begin miscompares++; $display("FAIL flush_valid e=%0d got %b want %b", e, hart_valid, (e >= 16)); end
      vectors++; if (slot0 !== (eid == 4'd0)) begin miscompares++; $display("FAIL flush_slot0 e=%0d got %b want %b", e, slot0, (eid == 4'd0)); end
      vectors++; if (all_asleep !== 1'b0) begin miscompares++; $display("FAIL flush_all_asleep e=%0d got %b want 0", e, all_asleep); end
      vectors++; if (hart_valid2 !== ((e >= 16) && (eid == 4'd0))) begin miscompares++; $display("FAIL flush_valid_mask e=%0d got %b want %b", e, hart_valid2, ((e >= 16) && (eid == 4'd0))); end
    end
  endtask

  task automatic test_sleep_one;
    while (eid != 4'd4) step();
    sleep_valid = 1'b1; sleep_id = 4'd5;
    step();
    sleep_valid = 1'b0;
    // The slot being issued on the request edge is hart 5 and is not affected.
    vectors++; if (hart_id !== 4'd5) begin miscompares++; $display("FAIL sleep_edge_id got %0d want 5", hart_id); end
    vectors++; if (hart_valid !== 1'b1) begin miscompares++; $display("FAIL sleep_edge_valid got %b want 1", hart_valid); end
    repeat (32) begin
      step();
      vectors++; if (hart_valid !== (eid != 4'd5)) begin miscompares++; $display("FAIL sleep5_valid id=%0d got %b want %b", eid, hart_valid, (eid != 4'd5)); end
      vectors++; if (all_asleep !== 1'b0) begin miscompares++; $display("FAIL sleep5_all_asleep got %b want 0", all_asleep); end
    end
  endtask

  task automatic test_sleep_wake_same;
    while (eid != 4'd0) step();
    sleep_valid = 1'b1; sleep_id = 4'd3; wake_mask = 16'h0008;
    step();
    sleep_valid = 1'b0; wake_mask = 16'h0000;
    repeat (16) begin
      step();
      vectors++; if (hart_valid !== (eid != 4'd5)) begin miscompares++; $display("FAIL same_cycle_valid id=%0d got %b want %b", eid, hart_valid, (eid != 4'd5)); end
    end
  endtask

  task automatic test_all_asleep;
    for (int h = 0; h < 16; h++) begin
      sleep_valid = 1'b1; sleep_id = 4'(h);
      step();
      vectors++; if (all_asleep !== (h == 15)) begin miscompares++; $display("FAIL all_asleep_h%0d got %b want %b", h, all_asleep, (h == 15)); end
    end
    sleep_valid = 1'b0;
    step();
    vectors++; if (all_asleep !== 1'b1) begin miscompares++; $display("FAIL all_asleep_hold got %b want 1", all_asleep); end
    vectors++; if (hart_valid !== 1'b0) begin miscompares++; $display("FAIL all_asleep_valid got %b want 0", hart_valid); end
    wake_mask = 16'h0001;
    step();
    wake_mask = 16'h0000;
    vectors++; if (all_asleep !== 1'b0) begin miscompares++; $display("FAIL wake0_all_asleep got %b want 0", all_asleep); end
    vectors++; if (hart_valid !== 1'b0) begin miscompares++; $display("FAIL wake0_edge_valid got %b want 0", hart_valid); end
    repeat (16) begin
      step();
      vectors++; if (hart_valid !== (eid == 4'd0)) begin miscompares++; $display("FAIL wake0_valid id=%0d got %b want %b", eid, hart_valid, (eid == 4'd0)); end
    end
  endtask

  task automatic test_reset_mid_run;
    wake_mask = 16'hffff;
    step();
    wake_mask = 16'h0000; sleep_valid = 1'b1; sleep_id = 4'd7;
    step();
    sleep_valid = 1'b0;
    repeat (16) begin
      step();
      vectors++; if (hart_valid !== (eid != 4'd7)) begin miscompares++; $display("FAIL pre_reset_valid id=%0d got %b want %b", eid, hart_valid, (eid != 4'd7)); end
    end
    reset = 1'b1;
    step();
    vectors++; if (hart_id !== 4'd0) begin miscompares++; $display("FAIL midreset_id got %0d want 0", hart_id); end
    vectors++; if (hart_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got %b want 0", hart_valid); end
    vectors++; if (slot0 !== 1'b0) begin miscompares++; $display("FAIL midreset_slot0 got %b want 0", slot0); end
    vectors++; if (all_asleep !== 1'b0) begin miscompares++; $display("FAIL midreset_all_asleep got %b want 0", all_asleep); end
    reset = 1'b0;
    e = -1;
    repeat (32) begin
      step();
      vectors++; if (hart_id !== eid) begin miscompares++; $display("FAIL reflush_id e=%0d got %0d want %0d", e, hart_id, eid); end
      vectors++; if (hart_valid !== (e >= 16)) begin miscompares++; $display("FAIL reflush_valid e=%0d got %b want %b", e, hart_valid, (e >= 16)); end
    end
  endtask

  task automatic test_reset_mask;
    reset = 1'b1;
    step();
    reset = 1'b0;
    e = -1;
    repeat (32) begin
      step();
      vectors++; if (hart_id2 !== eid) begin miscompares++; $display("FAIL mask_id e=%0d got %0d want %0d", e, hart_id2, eid); end
      vectors++; if (hart_valid2 !== ((e >= 16) && (eid == 4'd0))) begin miscompares++; $display("FAIL mask_valid e=%0d got %b want %b", e, hart_valid2, ((e >= 16) && (eid == 4'd0))); end
      vectors++; if (slot02 !== (eid == 4'd0)) begin miscompares++; $display("FAIL mask_slot0 e=%0d got %b want %b", e, slot02, (eid == 4'd0)); end
    end
  endtask

  initial begin
    reset = 1'b1; sleep_valid = 1'b0; sleep_id = 4'd0; wake_mask = 16'h0000;
    sleep_valid2 = 1'b0; sleep_id2 = 4'd0; wake_mask2 = 16'h0000;
    eid = 4'd0;
    @(negedge clk);
    test_reset();
    test_flush_run();
    test_sleep_one();
    test_sleep_wake_same();
    test_all_asleep();
    test_reset_mid_run();
    test_reset_mask();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1);
  end

endmodule
